// File: rtl/io_buffer_pkg.sv
// Shared types and default geometry for the I/O buffer packer.
// The state enum is shared so that other blocks can decode the packer state consistently.
package io_buffer_pkg;

  localparam int IO_ADDR_WIDTH = 6;
  localparam int IO_DATA_WIDTH = 256;
  localparam int IO_WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    RD_REQ,
    DRAIN
  } io_pack_state_t;

endpackage

// File: rtl/io_buffer_packer.sv
// Bus-side adapter: packs narrow write words into one buffer line, and
// unpacks a read line back into narrow words, with valid/ready on both sides.
module io_buffer_packer
  import io_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = IO_ADDR_WIDTH,
  parameter int DATA_WIDTH = IO_DATA_WIDTH,
  parameter int WORD_WIDTH = IO_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  buf_write_enable,
  output logic                  buf_read_enable,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [DATA_WIDTH-1:0] buf_data_in,
  input  logic [DATA_WIDTH-1:0] buf_data_out
);

  localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  if (DATA_WIDTH % WORD_WIDTH != 0) begin : g_width_check
    $error("io_buffer_packer: DATA_WIDTH must be a multiple of WORD_WIDTH");
  end

  io_pack_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Next-state logic; the word counter only wraps by leaving FILL or DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = '0;
          state_d = cmd_write ? FILL : RD_REQ;
        end
      end
      FILL: begin
        if (in_valid) begin
          line_d[cnt_q*WORD_WIDTH +: WORD_WIDTH] = in_data;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      RD_REQ: begin
        line_d  = buf_data_out;
        cnt_d   = '0;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the registered state; reset forces them low in the same cycle.
  always_comb begin
    cmd_ready        = 1'b0;
    in_ready         = 1'b0;
    out_valid        = 1'b0;
    out_data         = '0;
    out_last         = 1'b0;
    buf_write_enable = 1'b0;
    buf_read_enable  = 1'b0;
    buf_addr         = '0;
    buf_data_in      = '0;
    busy             = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE:  cmd_ready = 1'b1;
        FILL:  in_ready  = 1'b1;
        WRITE: begin
          buf_write_enable = 1'b1;
          buf_addr         = addr_q;
          buf_data_in      = line_q;
        end
        RD_REQ: begin
          buf_read_enable = 1'b1;
          buf_addr        = addr_q;
        end
        DRAIN: begin
          out_valid = 1'b1;
          out_data  = line_q[cnt_q*WORD_WIDTH +: WORD_WIDTH];
          out_last  = (cnt_q == LAST_CNT);
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_io_buffer_packer.sv
// Self-checking bench for io_buffer_packer: directed scenarios plus random
// write/read round trips against a word-level reference memory.
module tb_io_buffer_packer;
  import io_buffer_pkg::*;

  localparam int AW    = IO_ADDR_WIDTH;
  localparam int DW    = IO_DATA_WIDTH;
  localparam int WW    = IO_WORD_WIDTH;
  localparam int WORDS = DW / WW;
  localparam int LINES = 2 ** AW;

  typedef logic [WW-1:0] words_t [WORDS];

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic          in_valid, in_ready;
  logic [WW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [WW-1:0] out_data;
  logic          busy, buf_write_enable, buf_read_enable;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data_in, buf_data_out;

  io_buffer_packer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .WORD_WIDTH(WW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy),
    .buf_write_enable(buf_write_enable),
    .buf_read_enable(buf_read_enable),
    .buf_addr(buf_addr),
    .buf_data_in(buf_data_in),
    .buf_data_out(buf_data_out)
  );

  always #5 clk = ~clk;

  // Downstream line buffer with combinational read.
  logic [DW-1:0] buf_mem [LINES];
  logic          mem_clear;
  assign buf_data_out = buf_mem[buf_addr];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < LINES; i++) buf_mem[i] <= '0;
    end else if (buf_write_enable) begin
      buf_mem[buf_addr] <= buf_data_in;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Pulse monitor, sampled well after the falling edge.
  int            wr_pulses = 0, rd_pulses = 0, both_hi = 0;
  int            wr_cyc = -1, rd_cyc = -1;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  always @(negedge clk) begin
    #2;
    if (buf_write_enable) begin
      wr_pulses = wr_pulses + 1;
      wr_cyc    = cyc;
      wr_addr   = buf_addr;
      wr_data   = buf_data_in;
    end
    if (buf_read_enable) begin
      rd_pulses = rd_pulses + 1;
      rd_cyc    = cyc;
      rd_addr   = buf_addr;
    end
    if (buf_write_enable && buf_read_enable) both_hi = both_hi + 1;
  end

  words_t ref_mem [LINES];
  int     total = 0, bad = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack_words(input words_t w);
    logic [DW-1:0] p;
    p = '0;
    for (int i = 0; i < WORDS; i++) p[i*WW +: WW] = w[i];
    return p;
  endfunction

  task automatic reset_pulse(input string tag);
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_wr_en"}, buf_write_enable, 0);
    checkOutput({tag, "_rd_en"}, buf_read_enable, 0);
    @(negedge clk);
    #1;
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_buf_addr"}, buf_addr, 0);
    checkOutput({tag, "_buf_data_in"}, buf_data_in, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle_cmd_ready"}, cmd_ready, 1);
    checkOutput({tag, "_idle_busy"}, busy, 0);
    checkOutput({tag, "_idle_out_valid"}, out_valid, 0);
  endtask

  // Issues a command and returns the cycle of its handshake.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input bit hold,
                               output int t_hs);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    for (int k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
    checkOutput("cmd_accept", cmd_ready, 1);
    t_hs = cyc;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic send_words(input words_t w, input int gap, input bit chk_stall,
                            output int last_cyc);
    last_cyc = -1;
    for (int i = 0; i < WORDS; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        if (chk_stall) begin
          checkOutput("gap_busy", busy, 1);
          checkOutput("gap_cmd_ready", cmd_ready, 0);
        end
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = w[i];
      for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
      checkOutput("in_accept", in_ready, 1);
      last_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_write(input logic [AW-1:0] addr, input words_t w, input int t_hs,
                             input int last_cyc, input int base, input bit best);
    repeat (2) @(negedge clk);
    checkOutput("wr_pulse_count", wr_pulses - base, 1);
    checkOutput("wr_pulse_cycle", wr_cyc, last_cyc + 1);
    checkOutput("wr_addr", wr_addr, addr);
    checkOutput("wr_data", wr_data, pack_words(w));
    if (best) begin
      checkOutput("wr_last_word_cycle", last_cyc - t_hs, WORDS);
      checkOutput("wr_latency", wr_cyc - t_hs, WORDS + 1);
    end
    ref_mem[addr] = w;
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random.
  task automatic read_check(input logic [AW-1:0] addr, input int t_hs, input int mode,
                            input int base);
    int            idx, first, last_hs, v;
    bit            stall;
    logic [WW-1:0] pd;
    logic          pl, r;
    idx = 0; first = -1; last_hs = -1; v = 0; stall = 1'b0; pd = '0; pl = 1'b0;
    for (int k = 0; k < 300 && idx < WORDS; k++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (v % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (stall) begin
          checkOutput("stall_data_stable", out_data, pd);
          checkOutput("stall_last_stable", out_last, pl);
        end
        if (r) begin
          checkOutput("rd_word", out_data, ref_mem[addr][idx]);
          checkOutput("rd_last", out_last, (idx == WORDS - 1));
          last_hs = cyc;
          idx++;
        end
        stall = !r;
        pd    = out_data;
        pl    = out_last;
        v++;
      end else begin
        stall = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checkOutput("rd_word_count", idx, WORDS);
    checkOutput("rd_no_extra", out_valid, 0);
    checkOutput("rd_pulse_count", rd_pulses - base, 1);
    checkOutput("rd_pulse_cycle", rd_cyc, t_hs + 1);
    checkOutput("rd_addr", rd_addr, addr);
    checkOutput("rd_first_valid", first, t_hs + 2);
    if (mode == 0) checkOutput("rd_last_cycle", last_hs, t_hs + WORDS + 1);
  endtask

  initial begin
    words_t        w;
    int            t, lc, base_w, base_r, got;
    logic [AW-1:0] a;

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; mem_clear = 1'b1;
    for (int l = 0; l < LINES; l++)
      for (int i = 0; i < WORDS; i++) ref_mem[l][i] = '0;
    @(negedge clk);
    reset_pulse("init");
    mem_clear = 1'b0;

    $display("[TB] stray in_valid while idle");
    in_valid = 1'b1;
    in_data  = 32'hdeadbeef;
    repeat (2) begin
      checkOutput("idle_in_ready", in_ready, 0);
      checkOutput("idle_busy", busy, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    $display("[TB] directed write/read of addr 5");
    for (int i = 0; i < WORDS; i++) w[i] = 32'h11111111 * (i + 1);
    base_w = wr_pulses;
    applyStimulus(1'b1, 6'd5, 1'b0, t);
    send_words(w, 0, 1'b0, lc);
    check_write(6'd5, w, t, lc, base_w, 1'b1);
    checkOutput("wr_line_constant", wr_data,
                256'h88888888777777776666666655555555444444443333333322222222_11111111);
    base_r = rd_pulses;
    applyStimulus(1'b0, 6'd5, 1'b0, t);
    read_check(6'd5, t, 0, base_r);
    base_r = rd_pulses;
    applyStimulus(1'b0, 6'd5, 1'b0, t);
    read_check(6'd5, t, 1, base_r);

    $display("[TB] sparse write with held command");
    for (int i = 0; i < WORDS; i++) w[i] = $urandom();
    base_w = wr_pulses;
    base_r = rd_pulses;
    applyStimulus(1'b1, 6'd9, 1'b1, t);
    cmd_write = 1'b0;
    send_words(w, 2, 1'b1, lc);
    check_write(6'd9, w, t, lc, base_w, 1'b0);
    cmd_valid = 1'b0;
    read_check(6'd9, wr_cyc + 1, 2, base_r);

    $display("[TB] back-to-back write then read of addr 0");
    for (int i = 0; i < WORDS; i++) w[i] = $urandom();
    base_w = wr_pulses;
    base_r = rd_pulses;
    applyStimulus(1'b1, 6'd0, 1'b1, t);
    cmd_write = 1'b0;
    send_words(w, 0, 1'b0, lc);
    check_write(6'd0, w, t, lc, base_w, 1'b1);
    cmd_valid = 1'b0;
    read_check(6'd0, wr_cyc + 1, 0, base_r);

    $display("[TB] reset mid-fill, then top address");
    base_w = wr_pulses;
    applyStimulus(1'b1, 6'd7, 1'b0, t);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      checkOutput("partial_in_ready", in_ready, 1);
      @(negedge clk);
    end
    reset_pulse("rst_fill");
    checkOutput("partial_no_write", wr_pulses - base_w, 0);
    for (int i = 0; i < WORDS; i++) w[i] = $urandom();
    base_w = wr_pulses;
    applyStimulus(1'b1, 6'd63, 1'b0, t);
    send_words(w, 0, 1'b0, lc);
    check_write(6'd63, w, t, lc, base_w, 1'b1);
    base_r = rd_pulses;
    applyStimulus(1'b0, 6'd63, 1'b0, t);
    read_check(6'd63, t, 2, base_r);
    base_r = rd_pulses;
    applyStimulus(1'b0, 6'd7, 1'b0, t);
    read_check(6'd7, t, 0, base_r);

    $display("[TB] reset mid-drain");
    applyStimulus(1'b0, 6'd5, 1'b0, t);
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      if (out_valid) got++;
      @(negedge clk);
    end
    reset_pulse("rst_drain");

    $display("[TB] reset during write pulse");
    for (int i = 0; i < WORDS; i++) w[i] = $urandom();
    base_w = wr_pulses;
    applyStimulus(1'b1, 6'd12, 1'b0, t);
    send_words(w, 0, 1'b0, lc);
    reset_pulse("rst_write");
    checkOutput("rst_write_no_pulse", wr_pulses - base_w, 0);
    base_r = rd_pulses;
    applyStimulus(1'b0, 6'd12, 1'b0, t);
    read_check(6'd12, t, 0, base_r);

    $display("[TB] reset during read request");
    base_r = rd_pulses;
    applyStimulus(1'b0, 6'd9, 1'b0, t);
    reset_pulse("rst_rdreq");
    checkOutput("rst_rdreq_no_pulse", rd_pulses - base_r, 0);

    $display("[TB] random round trips");
    for (int n = 0; n < 6; n++) begin
      a = AW'($urandom());
      for (int i = 0; i < WORDS; i++) w[i] = $urandom();
      base_w = wr_pulses;
      applyStimulus(1'b1, a, 1'b0, t);
      send_words(w, $urandom_range(0, 1), 1'b0, lc);
      check_write(a, w, t, lc, base_w, 1'b0);
      base_r = rd_pulses;
      applyStimulus(1'b0, a, 1'b0, t);
      read_check(a, t, 2, base_r);
    end

    checkOutput("enables_never_together", both_hi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_buffer_packer.md
Name: io_buffer_packer

Overview:
Bus-side adapter that sits directly upstream of the line-wide I/O buffer.
- Write path: accepts narrow WORD_WIDTH words over a valid/ready stream, packs WORDS of them into one DATA_WIDTH line, then issues a single-cycle write to the buffer at a commanded line address.
- Read path: on a read command, pulses the buffer read enable, captures the returned line, and streams it back out as WORDS narrow words with valid/ready backpressure.

Parameters:
- ADDR_WIDTH, 6, line address width of the downstream buffer.
- DATA_WIDTH, 256, buffer line width.
- WORD_WIDTH, 32, bus word width. DATA_WIDTH % WORD_WIDTH must be 0, otherwise elaboration error. Derived WORDS = DATA_WIDTH/WORD_WIDTH.

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write line, 0 = read line
- cmd_addr  in  ADDR_WIDTH  target line address
- in_valid  in  1  write word valid
- in_ready  out  1  write word accepted
- in_data  in  WORD_WIDTH  write word
- out_valid  out  1  read word valid
- out_ready  in  1  read word consumed
- out_data  out  WORD_WIDTH  read word
- out_last  out  1  marks final word of a line
- busy  out  1  high whenever state != IDLE
- buf_write_enable  out  1  to buffer write_enable
- buf_read_enable  out  1  to buffer read_enable
- buf_addr  out  ADDR_WIDTH  to buffer addr
- buf_data_in  out  DATA_WIDTH  to buffer data_in
- buf_data_out  in  DATA_WIDTH  from buffer data_out (combinational read)

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, word counter=0, line register=0, latched addr=0.
- While rst is high, all handshake outputs, both buf enables and busy are 0. out_data, buf_addr and buf_data_in are 0 after reset.
- States: IDLE, FILL, WRITE, RD_REQ, DRAIN.
- IDLE:
  - cmd_ready=1, in_ready=0, out_valid=0.
  - On a cmd handshake, latch cmd_addr.
  - cmd_write=1: go to FILL with counter=0.
  - cmd_write=0: go to RD_REQ.
- FILL:
  - in_ready=1.
  - Each in handshake stores in_data into line bits [cnt*WORD_WIDTH +: WORD_WIDTH] and increments cnt.
  - The handshake with cnt==WORDS-1 moves to WRITE.
  - No timeout; gaps in in_valid simply stall.
- WRITE:
  - For exactly one cycle: buf_write_enable=1, buf_addr=latched addr, buf_data_in=line register.
  - Then go to IDLE.
- RD_REQ:
  - For exactly one cycle: buf_read_enable=1, buf_addr=latched addr.
  - buf_data_out is captured into the line register at the end of that cycle.
  - Then go to DRAIN with cnt=0.
- DRAIN:
  - out_valid=1, out_data=line[cnt*WORD_WIDTH +: WORD_WIDTH], out_last=(cnt==WORDS-1).
  - out_data and out_last are held stable while out_ready=0.
  - Each handshake increments cnt; the last handshake goes to IDLE.
- Word order: word 0 maps to line LSBs, in both directions.
- Outside WRITE/RD_REQ, buf_addr=0 and both buf enables are 0. The two enables are never high together.
- Latency, with the cmd handshake in cycle T:
  - Write: best case, words are accepted in T+1..T+WORDS and the write pulse is in T+WORDS+1.
  - Read: buf_read_enable is high in T+1, first out_valid in T+2, last word at T+WORDS+1 if out_ready stays high.
- Boundary cases:
  - in_valid outside FILL is ignored (in_ready=0).
  - cmd_valid while busy stalls; cmd_ready stays 0.
  - The command issued in the cycle the FSM returns to IDLE is accepted on the following cycle.
  - cmd_addr=2**ADDR_WIDTH-1 is legal with no wrap. The counter wraps only through the state exit.
  - Reset mid-FILL: partial line discarded, no write pulse.
  - Reset mid-DRAIN: remaining words dropped, out_valid=0 from the next cycle.
  - Reset during WRITE or RD_REQ: the enable drops in the reset cycle.

Decomposition:
- Package io_buffer_pkg holds:
  - the state enum typedef (io_pack_state_t);
  - default localparams IO_ADDR_WIDTH=6, IO_DATA_WIDTH=256, IO_WORD_WIDTH=32.
- The counter width is $clog2(WORDS), computed locally.
- Single module, no sub-module.
- Integration: buf_* ports connect one-to-one to the buffer instance.

Test Plan:
- Reset, write cmd addr 5, words 0x11111111..0x88888888 back-to-back -> one buf_write_enable pulse 9 cycles after cmd, buf_addr=5, buf_data_in=0x88888888_..._11111111.
- Read cmd addr 5 against a buffer model holding that line -> buf_read_enable high exactly one cycle, out words 0x11111111 first through 0x88888888, out_last only on the 8th.
- Same read with out_ready pattern 1,0,0,1,... -> out_data/out_last stable during stalls, all 8 words in order, no duplicates.
- Write with in_valid high every third cycle -> no write pulse until the 8th accepted word; busy high throughout; cmd_ready=0 if cmd_valid is held.
- Reset after 3 words of a write to addr 7 -> no write pulse; then write addr 63, read addr 63 -> data matches, addr 7 line unchanged (0).
- Back-to-back write addr 0 then read addr 0 with cmd_valid held -> second cmd accepted one cycle after IDLE re-entry, returned words equal written words.
